// File: rtl/uart_tx_byte.sv
// Byte-wide UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) with a
// level-held load handshake that re-arms only after atx_load has been seen low.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] atx_data,
  input  logic        atx_load,
  output logic        atx_busy,
  output logic        txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            armed_q, armed_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            bit_end;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic unused_hi;
  assign unused_hi = ^atx_data[15:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    armed_d = armed_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (cnt_q == LAST);

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (atx_load && armed_q) begin
          shift_d = atx_data[7:0];
          armed_d = 1'b0;
          cnt_d   = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^atx_data[7:0];
`endif
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A low load sample re-arms, including during a frame in flight.
    if (!atx_load) armed_d = 1'b1;
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  assign atx_busy = busy_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Bench for uart_tx_byte: CLKS_PER_BIT=4 and =2 instances checked cycle by cycle
// against a frame model built from the byte (start, LSB-first data, optional parity, stop).
module tb_uart_tx_byte;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data4, data2;
  logic        load4, load2;
  logic        busy4, txd4, busy2, txd2;
  int          errors = 0;
  int          checks = 0;
  bit          use2 = 1'b0;

  always #5 clk = ~clk;

  uart_tx_byte #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .atx_data(data4), .atx_load(load4),
    .atx_busy(busy4), .txd(txd4)
  );

  uart_tx_byte #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .atx_data(data2), .atx_load(load2),
    .atx_busy(busy2), .txd(txd2)
  );

  function automatic logic obs_busy();
    return use2 ? busy2 : busy4;
  endfunction

  function automatic logic obs_txd();
    return use2 ? txd2 : txd4;
  endfunction

  task automatic set_load(input logic v);
    if (use2) load2 = v; else load4 = v;
  endtask

  task automatic set_data(input logic [15:0] v);
    if (use2) data2 = v; else data4 = v;
  endtask

  // Line level for bit period k of a frame carrying byte b.
  function automatic logic model_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NBITS == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!obs_busy() && n < budget);
    checks++;
    if (obs_busy() !== 1'b1) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required 1", name, obs_busy(), n);
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input int cpb, input bit fw, input string name);
    for (int k = 0; k < NBITS * cpb; k++) begin
      if (fw && k == 1) set_load(1'b0);
      if (fw && k == 2 * cpb + 1) set_data(16'($urandom));
      checks++;
      if (obs_txd() !== model_bit(b, k / cpb)) begin
        errors++;
        $display("FAIL %s txd cycle %0d: got %b, required %b", name, k, obs_txd(), model_bit(b, k / cpb));
      end
      checks++;
      if (obs_busy() !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b, required 1", name, k, obs_busy());
      end
      @(negedge clk);
    end
    checks++;
    if (obs_busy() !== 1'b0 || obs_txd() !== 1'b1) begin
      errors++;
      $display("FAIL %s end: busy=%b txd=%b, required busy=0 txd=1", name, obs_busy(), obs_txd());
    end
  endtask

  task automatic expect_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      checks++;
      if (obs_busy() !== 1'b0 || obs_txd() !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b txd=%b, required busy=0 txd=1", name, i, obs_busy(), obs_txd());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load4 = 1'b0; load2 = 1'b0;
    data4 = 16'h0000; data2 = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || txd4 !== 1'b1 || busy2 !== 1'b0 || txd2 !== 1'b1) begin
      errors++;
      $display("FAIL reset: busy4=%b txd4=%b busy2=%b txd2=%b, required 0 1 0 1", busy4, txd4, busy2, txd2);
    end
    data4 = 16'h1255;
    load4 = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_idle("load_through_reset", 10);
  endtask

  task automatic test_first_frame();
    load4 = 1'b0;
    @(negedge clk);
    load4 = 1'b1;
    wait_busy("accept_1255", 1);
    check_frame(8'h55, 4, 1'b0, "frame_1255");
  endtask

  task automatic test_hold();
    expect_idle("no_repeat_1255", 20);
    data4 = 16'h0041;
    load4 = 1'b0;
    @(negedge clk);
    load4 = 1'b1;
    wait_busy("accept_41", 1);
    check_frame(8'h41, 4, 1'b0, "frame_41_held");
    expect_idle("no_repeat_41", 60);
  endtask

  task automatic test_firmware();
    logic [7:0] bytes [3] = '{8'h55, 8'hAA, 8'h0D};
    load4 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      data4 = {8'hC3, bytes[i]};
      load4 = 1'b1;
      wait_busy("accept_fw", 1);
      check_frame(bytes[i], 4, 1'b1, "frame_fw");
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      expect_idle("rand_gap", $urandom_range(0, 3));
      data4 = {8'($urandom), b};
      load4 = 1'b1;
      wait_busy("accept_rand", 1);
      check_frame(b, 4, 1'b1, "frame_rand");
    end
  endtask

  task automatic test_reset_mid();
    data4 = 16'h00FF;
    load4 = 1'b1;
    wait_busy("accept_ff", 1);
    repeat (18) @(negedge clk);
    checks++;
    if (busy4 !== 1'b1 || txd4 !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_ff: busy=%b txd=%b, required busy=1 txd=1", busy4, txd4);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy4 !== 1'b0 || txd4 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: busy=%b txd=%b, required busy=0 txd=1", busy4, txd4);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_idle("after_reset_load_high", 15);
    load4 = 1'b0;
    @(negedge clk);
    load4 = 1'b1;
    wait_busy("accept_ff_again", 1);
    check_frame(8'hFF, 4, 1'b1, "frame_ff");
  endtask

  task automatic test_parity();
    data4 = 16'h0041;
    load4 = 1'b1;
    wait_busy("accept_par41", 1);
    check_frame(8'h41, 4, 1'b1, "frame_par41");
    data4 = 16'h0007;
    load4 = 1'b1;
    wait_busy("accept_par07", 1);
    check_frame(8'h07, 4, 1'b1, "frame_par07");
  endtask

  task automatic test_back_to_back();
    use2 = 1'b1;
    data2 = 16'h0000;
    load2 = 1'b1;
    wait_busy("accept_b2b_00", 1);
    check_frame(8'h00, 2, 1'b1, "frame_b2b_00");
    data2 = 16'h00FF;
    load2 = 1'b1;
    wait_busy("accept_b2b_ff", 1);
    check_frame(8'hFF, 2, 1'b1, "frame_b2b_ff");
    expect_idle("b2b_tail", 10);
    use2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_hold();
    test_firmware();
    test_random();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_byte.md
# uart_tx_byte

Serial transmitter that consumes the CPU's `atx_data` / `atx_load` output words and returns `atx_busy` as an input word. It serialises the low byte of `atx_data` as an 8N1 frame on the board TX pin of the DE0-Nano. A level-held load handshake with re-arm is used, so a firmware routine that raises `atx_load`, polls `atx_busy`, then clears `atx_load` sends exactly one byte.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `atx_data`  in  16  CPU output word; bits [7:0] are transmitted, bits [15:8] are ignored.
- `atx_load`  in  1  level request from the CPU output word (bit 0).
- `atx_busy`  out  1  high from frame acceptance until the stop bit ends.
- `txd`  out  1  serial line, idle high.

## Operation
- Registers:
  - `state` ∈ {IDLE, START, DATA, PARITY, STOP}
  - baud counter, width clog2(CLKS_PER_BIT)
  - 3-bit bit index
  - 8-bit shift register
  - `armed` flag
- Re-arm rule:
  - `armed` clears when a frame is accepted.
  - `armed` sets on any clock where `atx_load` is sampled 0.
- IDLE:
  - `txd`=1, `atx_busy`=0.
  - If `atx_load`=1 and `armed`=1: latch `atx_data[7:0]`, clear `armed`, go to START.
- START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- DATA:
  - `txd` = shift[0]; shift right once per bit; LSB first.
  - After index 7 completes, go to PARITY if configured, otherwise STOP.
- PARITY (only when the macro is defined): `txd` = XOR of the latched byte, i.e. even parity, for one bit period.
- STOP: `txd`=1 for one bit period, then go to IDLE.
- `atx_busy`=1 in every state except IDLE.
- During a frame, changes on `atx_data` and `atx_load` do not affect the byte in flight. `atx_load` low during a frame still sets `armed`.
- If `atx_load` is still high when the frame ends: stay in IDLE with `armed`=0; no repeat send.
- Load held high through reset: no frame is sent until `atx_load` has been seen low once, because `armed` resets to 0.
- Reset assertion mid-frame: all registers clear immediately (asynchronously); frame aborted. Outputs go to `txd`=1, `atx_busy`=0, state IDLE, `armed`=0.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at the end of each bit, advancing the state/index.

## Timing
- Reset values: `txd`=1, `atx_busy`=0, state IDLE, `armed`=0, counters 0, shift register 0.
- Acceptance latency:
  - `atx_load` high is sampled at edge N.
  - `atx_busy`=1 and `txd`=0 are visible after edge N.
  - Both outputs are registered; no combinational path from inputs.
- Frame length:
  - Exactly 10×CLKS_PER_BIT cycles from `atx_busy` rise to fall.
  - 11×CLKS_PER_BIT with parity.
  - `atx_busy` falls on the same edge that `txd` completes the stop bit.
- Minimum gap between frames: one cycle with `atx_load`=0 (re-arm). The next frame can start on the edge after `atx_busy` falls, if re-armed and load is high.
- `atx_busy` rises within one cycle, so the CPU busy-poll loop always observes it before clearing load.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state compiled in; an even-parity bit is sent after D7.
  - Frame is 11 bit periods (8E1).
- `UART_TX_PARITY_EN` undefined:
  - PARITY state and XOR logic absent.
  - Frame is 10 bit periods (8N1); DATA goes directly to STOP.

## Test plan
Use CLKS_PER_BIT=4 unless noted.
- Reset, then `atx_data`=0x1255 with load held 1 → no frame (`armed`=0). Then load 0 for 1 cycle and load 1 → `atx_busy` rises next edge. `txd` sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles. `atx_busy` high for 40 cycles.
- Load held 1 for 60 cycles with `atx_data`=0x0041 → exactly one frame (bits 0,1,0,0,0,0,0,1,0,1); `txd` stays 1 after it.
- Firmware-style handshake:
  - Send 0x55, 0xAA, 0x0D, dropping load on the cycle after `atx_busy` rises.
  - Change `atx_data` mid-frame.
  - Expect three frames with the originally latched bytes, separated by ≥1 idle cycle.
- Assert `reset_n`=0 during DATA bit 3 of 0xFF → `txd`=1 and `atx_busy`=0 immediately, with no clock. After release with load=1, no transmission until load goes low.
- With `UART_TX_PARITY_EN`, send 0x41 (two ones) → parity bit 0. Send 0x07 → parity bit 1. `atx_busy` high 44 cycles.
- CLKS_PER_BIT=2, back-to-back bytes 0x00, 0xFF → frames of 20 cycles each; no dropped or repeated byte.
